// File: rtl/alu_mbyte_seq.sv
// Multi-byte operation sequencer for a shared, purely combinational 8-bit ALU.
// Walks one byte per clock, chains the carry and presents the assembled wide result.
module alu_mbyte_seq #(
  parameter int NBYTES = 2,
  localparam int W = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [2:0]   cmd,
  input  logic         cin,
  input  logic [W-1:0] opa,
  input  logic [W-1:0] opb,
  output logic [7:0]   alu_a,
  output logic [7:0]   alu_b,
  output logic         alu_carry,
  output logic [3:0]   alu_op,
  input  logic [7:0]   alu_c,
  input  logic         alu_cout,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         carry,
  output logic         zero,
  output logic [1:0]   state_dbg
);

  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  localparam logic [2:0] CMD_ADD = 3'd0;
  localparam logic [2:0] CMD_ADC = 3'd1;
  localparam logic [2:0] CMD_SUB = 3'd2;
  localparam logic [2:0] CMD_AND = 3'd3;
  localparam logic [2:0] CMD_OR  = 3'd4;
  localparam logic [2:0] CMD_XOR = 3'd5;
  localparam logic [2:0] CMD_SHL = 3'd6;
  localparam logic [2:0] CMD_SHR = 3'd7;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_ADC  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd12;
  localparam logic [3:0] OP_SHR  = 4'd13;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [2:0]      cmd_q;
  logic [W-1:0]    opa_q;
  logic [W-1:0]    opb_q;
  logic [W-1:0]    shadow;
  logic [IDXW-1:0] idx;
  logic            chain;

  logic            accept;
  logic            last_byte;
  logic [IDXW-1:0] pos;
  logic [7:0]      byte_a;
  logic [7:0]      byte_b;
  logic [7:0]      store_byte;
  logic [W-1:0]    shadow_nxt;
  logic            carry_fin;
  logic            chain_init;

  // Handshake: a request is taken on any rising edge where start=1 and busy=0
  // (IDLE or DONE); start while busy is dropped, not queued.
  assign accept    = start && !busy;
  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);
  assign last_byte = (idx == LAST_IDX);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last_byte) state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // SHR must walk MSB first so the bit shifted out of a higher byte can be
  // folded into the top of the next lower one.
  assign pos = (cmd_q == CMD_SHR) ? (LAST_IDX - idx) : idx;

  always_comb begin
    byte_a = 8'h00;
    byte_b = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (pos == IDXW'(i)) begin
        byte_a = opa_q[i*8 +: 8];
        byte_b = opb_q[i*8 +: 8];
      end
    end
  end

  always_comb begin
    alu_a     = 8'h00;
    alu_b     = 8'h00;
    alu_carry = 1'b0;
    alu_op    = OP_NONE;
    if (state == S_RUN) begin
      case (cmd_q)
        CMD_ADD, CMD_ADC: begin
          alu_op = OP_ADC; alu_a = byte_a; alu_b = byte_b; alu_carry = chain;
        end
        CMD_SUB: begin
          alu_op = OP_ADC; alu_a = byte_a; alu_b = ~byte_b; alu_carry = chain;
        end
        CMD_AND: begin alu_op = OP_AND; alu_a = byte_a; alu_b = byte_b; end
        CMD_OR:  begin alu_op = OP_OR;  alu_a = byte_a; alu_b = byte_b; end
        CMD_XOR: begin alu_op = OP_XOR; alu_a = byte_a; alu_b = byte_b; end
        CMD_SHL: begin alu_op = OP_SHL; alu_a = byte_a; end
        CMD_SHR: begin alu_op = OP_SHR; alu_a = byte_a; end
        default: alu_op = OP_NONE;
      endcase
    end
  end

  // For shifts the chain register holds the bit shifted out of the previous byte.
  always_comb begin
    store_byte = alu_c;
    if (cmd_q == CMD_SHL) store_byte[0] = alu_c[0] | chain;
    if (cmd_q == CMD_SHR) store_byte[7] = alu_c[7] | chain;
  end

  always_comb begin
    shadow_nxt = shadow;
    for (int i = 0; i < NBYTES; i++) begin
      if (pos == IDXW'(i)) shadow_nxt[i*8 +: 8] = store_byte;
    end
  end

  always_comb begin
    carry_fin = 1'b0;
    case (cmd_q)
      CMD_ADD, CMD_ADC: carry_fin = alu_cout;
      CMD_SUB:          carry_fin = ~alu_cout;
      CMD_SHL:          carry_fin = opa_q[W-1];
      CMD_SHR:          carry_fin = opa_q[0];
      default:          carry_fin = 1'b0;
    endcase
  end

  // SUB is A + ~B + 1, so the chain starts at 1; ADC starts from cin.
  always_comb begin
    chain_init = 1'b0;
    if (cmd == CMD_ADC) chain_init = cin;
    if (cmd == CMD_SUB) chain_init = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cmd_q  <= CMD_ADD;
      opa_q  <= '0;
      opb_q  <= '0;
      shadow <= '0;
      idx    <= '0;
      chain  <= 1'b0;
      result <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
    end else if (accept) begin
      cmd_q  <= cmd;
      opa_q  <= opa;
      opb_q  <= opb;
      shadow <= '0;
      idx    <= '0;
      chain  <= chain_init;
    end else if (state == S_RUN) begin
      shadow <= shadow_nxt;
      chain  <= alu_cout;
      if (last_byte) begin
        idx    <= '0;
        result <= shadow_nxt;
        carry  <= carry_fin;
        zero   <= ~|shadow_nxt;
      end else begin
        idx <= idx + IDXW'(1);
      end
    end
  end

endmodule

// File: doc/alu_mbyte_seq.md
Name: alu_mbyte_seq

Overview:
Sequencer that runs multi-byte (NBYTES x 8-bit) arithmetic, logic and shift operations on the existing 8-bit ALU, one byte per clock. It latches wide operands on a start handshake and drives the ALU's a/b/carry/op inputs each cycle. It chains the ALU carry between bytes and assembles the wide result, carry and zero flags. It sits between the register file/control FSM and a single shared ALU instance; the ALU is external and purely combinational.

Parameters:
NBYTES, 2, operand/result width in bytes (>=1); W = 8*NBYTES.

Ports:
clk  in  1  system clock; all state changes on the rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  request; sampled only when busy=0
cmd  in  3  0 ADD, 1 ADC, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SHL, 7 SHR
cin  in  1  carry-in, used by ADC only
opa  in  W  operand A
opb  in  W  operand B (ignored for SHL/SHR)
alu_a  out  8  ALU a input
alu_b  out  8  ALU b input
alu_carry  out  1  ALU carry input
alu_op  out  4  ALU op input
alu_c  in  8  ALU result byte (same cycle)
alu_cout  in  1  ALU carry_out (same cycle)
busy  out  1  operation in progress
done  out  1  one-cycle pulse, result valid
result  out  W  wide result, held until next accepted start
carry  out  1  final carry/borrow/shifted-out bit
zero  out  1  1 when result == 0

Behaviour:
- Reset (async, resetn=0): state IDLE; busy=0, done=0, result=0, carry=0, zero=0; internal operands, byte index and chain carry cleared. Reset mid-RUN aborts the operation; no done pulse.
- States: IDLE -> RUN on start; RUN -> DONE after byte NBYTES-1; DONE -> IDLE next cycle, or -> RUN if start is high in DONE.
- Accept: start with busy=0 (IDLE or DONE) latches cmd, cin, opa, opb; start during RUN is ignored.
- Timing: start sampled at edge 0; busy=1 for cycles 1..NBYTES; byte k is processed in cycle k+1 and registered at its end. done=1 and the new result/carry/zero are visible in cycle NBYTES+1. NBYTES=1 gives done one cycle after busy.
- Byte order: LSB first for ADD/ADC/SUB/logic/SHL; MSB first for SHR.
- ADD: alu_op=1 (adc), alu_b=B byte, initial chain carry 0.
- ADC: as ADD, initial chain carry = cin.
- SUB: alu_op=1, alu_b = ~B byte, initial chain carry 1.
- AND/OR/XOR: alu_op = 5/4/7, alu_carry=0, no chaining.
- SHL: alu_op=12, alu_carry=0. Stored byte = alu_c with bit0 ORed with the previous alu_cout (first byte: 0).
- SHR: alu_op=13, alu_carry=0. Stored byte = alu_c with bit7 ORed with the previous alu_cout (first byte: 0).
- Arithmetic chain: alu_carry = chain carry; chain carry <= alu_cout after every byte.
- alu_a/alu_b/alu_op/alu_carry are driven only from registered state. In IDLE/DONE they are 0, 0, 0 and 0.
- Final carry:
  - ADD/ADC: last alu_cout.
  - SUB: inverted last alu_cout (1 = borrow, A<B unsigned).
  - Logic ops: 0.
  - SHL: original A[W-1].
  - SHR: original A[0].
- zero is computed from the full assembled W-bit result and updated together with result. result, carry and zero update only at the DONE transition; intermediate bytes are held in a shadow register.

Test Plan (NBYTES=2):
- Reset, then ADD opa=0x00FF opb=0x0001 -> busy cycles 1-2, done cycle 3, result=0x0100, carry=0, zero=0.
- ADD 0xFFFF+0x0001 -> result=0x0000, carry=1, zero=1. ADC 0x1234+0x0001 with cin=1 -> 0x1236, carry=0.
- SUB 0x0100-0x0001 -> 0x00FF, carry=0. SUB 0x0001-0x0002 -> 0xFFFF, carry=1. SUB 0x5A5A-0x5A5A -> 0x0000, zero=1.
- SHL opa=0x80C0 -> 0x0180, carry=1. SHR opa=0x0181 -> 0x00C0, carry=1. XOR 0xF0F0^0xFF00 -> 0x0FF0, carry=0.
- Back-to-back: second start asserted in the DONE cycle is accepted, with no idle gap. Start pulsed during RUN is ignored, and the first result is unaffected.
- resetn low in cycle 1 of RUN -> busy=0, done never pulses, result=0. A following ADD 0x0002+0x0003 -> 0x0005.
